bf16_norm_round: RTL
====================

Name: bf16_norm_round

Overview:
- Normalisation and rounding stage directly downstream of the adder's leading-zero counter.
- Takes the raw, unnormalised mantissa sum plus the pre-shift exponent and sign.
- Instantiates lzc (W=16) on the padded mantissa, shifts left or right by the count, adjusts the exponent, rounds to nearest-even and packs a bfloat16 result.
- Two-stage pipeline with a valid/ready handshake on both sides.

Parameters:
- MANT_W, 12, raw mantissa width: {carry, hidden, frac[6:0], G, R, S}.
- LZC_W, 16, lzc input width: mant_i padded with 4'b0000 at the LSB end. Must be a power of 2.

Ports:
- clk  input  1  clock, all state on rising edge.
- nreset  input  1  asynchronous active-low reset.
- valid_i  input  1  input beat valid.
- ready_o  output  1  stage can accept a beat.
- sign_i  input  1  result sign from adder.
- exp_i  input  8  biased exponent of the larger operand.
- mant_i  input  12  raw sum. [11] carry, [10] hidden, [9:3] frac, [2] G, [1] R, [0] S.
- valid_o  output  1  result valid.
- ready_i  input  1  downstream accepts result.
- res_o  output  16  bfloat16 {sign, exp[7:0], frac[6:0]}.
- overflow_o  output  1  result saturated to infinity.
- underflow_o  output  1  result flushed to zero.
- inexact_o  output  1  any of G/R/S nonzero after normalisation, or underflow.

Behaviour:
- Reset: s1_valid, s2_valid, valid_o, res_o, all flags are 0; ready_o is 1 one cycle after nreset deasserts. Async assertion mid-operation drops all in-flight beats.
- Handshake:
  - s2 advances when !s2_valid | ready_i.
  - s1 advances when !s1_valid | s2 advance.
  - ready_o = s1 advance (combinational from ready_i).
  - Input transfer on valid_i & ready_o; output transfer on valid_o & ready_i.
  - While valid_o & !ready_i, res_o and the flags hold stable.
  - Latency 2 cycles; throughput 1 beat/cycle with ready_i held high.
- Stage 1:
  - c = lzc({mant_i, 4'b0000}), range 0..16.
  - Register sign, exp, mant and c.
- Stage 2, normalise:
  - c==0 (carry set): norm = {1'b0, mant[11:1]} with norm[0] = mant[1]|mant[0]; e = exp+1.
  - 1<=c<=11: norm = mant << (c-1); e = exp+1-c. e is computed signed, 10 bits.
  - c>=12 (mant==0): exact zero. res_o = 16'h0000 (sign forced 0), no flags set.
- Stage 2, round (RNE):
  - lsb = norm[3], G = norm[2], sticky = norm[1]|norm[0].
  - inc = G & (sticky | lsb).
  - {co, frac} = norm[9:3] + inc; co=1 gives frac=0 and e = e+1.
- Stage 2, range:
  - e >= 255: res_o = {sign, 8'hFF, 7'h00}, overflow_o=1, inexact_o=1.
  - e <= 0: res_o = {sign, 15'h0}, underflow_o=1, inexact_o=1. Flush-to-zero; no subnormals.
  - Otherwise res_o = {sign, e[7:0], frac}.
- Flags are valid only with valid_o.
- Simultaneous input and output transfer in the same cycle with both stages full: no bubble, no loss.

Test Plan:
- Carry normalisation: exp_i=127, mant_i=12'h800 -> after 2 cycles res_o=16'h4000, no flags.
- Cancellation: exp_i=127, mant_i=12'h008 (c=8) -> res_o=16'h3C00 (exp 120), no flags.
- RNE rounding:
  - Tie to even up: exp_i=127, mant_i=12'h40C -> res_o=16'h3F82, inexact_o=1.
  - Tie to even stays: mant_i=12'h404 -> res_o=16'h3F80, inexact_o=1.
  - Round-carry: mant_i=12'h7FC -> res_o=16'h4000.
- Range limits:
  - Overflow: exp_i=254, mant_i=12'h800 -> res_o=16'h7F80, overflow_o=1.
  - Underflow: exp_i=3, mant_i=12'h008 -> res_o=16'h0000, underflow_o=1.
  - Zero: mant_i=0, sign_i=1 -> res_o=16'h0000, no flags.
- Backpressure: stream 8 beats with ready_i low for 3 cycles mid-stream -> ready_o drops after 2 beats buffered; res_o stable while stalled; all 8 results in order, none lost or duplicated.
- Reset mid-flight: assert nreset low with 2 beats in flight -> valid_o=0 immediately; after release, no stale beat emerges and the first new beat returns correctly.

Source files
------------

// File: rtl/bf16_norm_round.sv
// bfloat16 normalise/round stage: LZC-driven shift, exponent adjust, RNE rounding,
// saturate/flush range handling. Two-stage valid/ready pipeline.

module lzc #(
  parameter int unsigned W  = 16,
  parameter int unsigned CW = $clog2(W) + 1
) (
  input  logic [W-1:0]  in_i,
  output logic [CW-1:0] cnt_o
);
  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    cnt_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (in_i[i]) cnt_o = CW'(W - 1 - i);
    end
  end
endmodule

module bf16_norm_round #(
  parameter int unsigned MANT_W = 12,
  parameter int unsigned LZC_W  = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              sign_i,
  input  logic [7:0]        exp_i,
  input  logic [MANT_W-1:0] mant_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [15:0]       res_o,
  output logic              overflow_o,
  output logic              underflow_o,
  output logic              inexact_o
);
  localparam int unsigned PAD_W = LZC_W - MANT_W;
  localparam int unsigned CW    = $clog2(LZC_W) + 1;
  localparam int unsigned EW    = 10;

  logic              init_q, init_d;
  logic              s1_valid_q, s1_valid_d;
  logic              s1_sign_q, s1_sign_d;
  logic [7:0]        s1_exp_q, s1_exp_d;
  logic [MANT_W-1:0] s1_mant_q, s1_mant_d;
  logic [CW-1:0]     s1_cnt_q, s1_cnt_d;
  logic              valid_q, valid_d;
  logic [15:0]       res_q, res_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              inx_q, inx_d;

  logic          s1_adv, s2_adv, in_fire;
  logic [CW-1:0] lzc_cnt;
  logic [9:0]    norm;
  logic [EW-1:0] e_pre, e_rnd;
  logic          inc, co;
  logic [6:0]    frac;
  logic [15:0]   s2_res;
  logic          s2_ovf, s2_unf, s2_inx;

  lzc #(.W(LZC_W), .CW(CW)) u_lzc (
    .in_i  ({mant_i, {PAD_W{1'b0}}}),
    .cnt_o (lzc_cnt)
  );

  assign s2_adv  = !valid_q || ready_i;
  assign s1_adv  = !s1_valid_q || s2_adv;
  assign ready_o = init_q && s1_adv;
  assign in_fire = valid_i && ready_o;

  // Normalise (norm[9:3] = frac, norm[2] = G, norm[1:0] = R/S), round, range-check.
  always_comb begin
    norm  = '0;
    e_pre = '0;
    if (s1_cnt_q == '0) begin
      norm  = {s1_mant_q[10:2], s1_mant_q[1] | s1_mant_q[0]};
      e_pre = {2'b00, s1_exp_q} + EW'(1);
    end else begin
      norm  = 10'(s1_mant_q << (s1_cnt_q - CW'(1)));
      e_pre = {2'b00, s1_exp_q} + EW'(1) - EW'(s1_cnt_q);
    end
    inc       = norm[2] & (norm[1] | norm[0] | norm[3]);
    {co, frac} = {1'b0, norm[9:3]} + 8'(inc);
    e_rnd     = e_pre + EW'(co);
    s2_res    = {s1_sign_q, e_rnd[7:0], frac};
    s2_ovf    = 1'b0;
    s2_unf    = 1'b0;
    s2_inx    = |norm[2:0];
    if (s1_cnt_q >= CW'(12)) begin
      s2_res = 16'h0000;
      s2_inx = 1'b0;
    end else if ($signed(e_rnd) >= $signed(EW'(255))) begin
      s2_res = {s1_sign_q, 8'hFF, 7'h00};
      s2_ovf = 1'b1;
      s2_inx = 1'b1;
    end else if ($signed(e_rnd) <= $signed(EW'(0))) begin
      s2_res = {s1_sign_q, 15'h0000};
      s2_unf = 1'b1;
      s2_inx = 1'b1;
    end
  end

  always_comb begin
    init_d     = 1'b1;
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_exp_d   = s1_exp_q;
    s1_mant_d  = s1_mant_q;
    s1_cnt_d   = s1_cnt_q;
    valid_d    = valid_q;
    res_d      = res_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    inx_d      = inx_q;
    if (s1_adv) begin
      s1_valid_d = in_fire;
      if (in_fire) begin
        s1_sign_d = sign_i;
        s1_exp_d  = exp_i;
        s1_mant_d = mant_i;
        s1_cnt_d  = lzc_cnt;
      end
    end
    if (s2_adv) begin
      valid_d = s1_valid_q;
      if (s1_valid_q) begin
        res_d = s2_res;
        ovf_d = s2_ovf;
        unf_d = s2_unf;
        inx_d = s2_inx;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      init_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_mant_q  <= '0;
      s1_cnt_q   <= '0;
      valid_q    <= 1'b0;
      res_q      <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      inx_q      <= 1'b0;
    end else begin
      init_q     <= init_d;
      s1_valid_q <= s1_valid_d;
      s1_sign_q  <= s1_sign_d;
      s1_exp_q   <= s1_exp_d;
      s1_mant_q  <= s1_mant_d;
      s1_cnt_q   <= s1_cnt_d;
      valid_q    <= valid_d;
      res_q      <= res_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      inx_q      <= inx_d;
    end
  end

  assign valid_o     = valid_q;
  assign res_o       = res_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;
  assign inexact_o   = inx_q;
endmodule
